// File: rtl/banda_pkg.sv
// Shared types and default constants for the sorting stage.
// Pure declarations: no timing, no flow control.
package banda_pkg;

    typedef enum logic {IDLE, EJECT} state_t;

    localparam int DELAY_DEF = 4;
    localparam int PULSE_DEF = 3;
    localparam int BATCH_DEF = 10;

endpackage

// File: rtl/banda_delay_line.sv
// DEPTH-stage shift register with synchronous clear; all stage contents exposed on o_taps.
// Latency DEPTH cycles from i_dat to o_dat; shifts every cycle, no backpressure.
module banda_delay_line #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic               clk,
    input  logic               i_clr,
    input  logic [W-1:0]       i_dat,
    output logic [DEPTH*W-1:0] o_taps,
    output logic [W-1:0]       o_dat
);

    logic [W-1:0] r_sr [DEPTH];

    always_ff @(posedge clk) begin
        if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
        end else begin
            r_sr[0] <= i_dat;
            for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_taps
        assign o_taps[g*W +: W] = r_sr[g];
    end

    assign o_dat = r_sr[DEPTH-1];

endmodule

// File: rtl/banda_sortare.sv
// Delays reject decisions to the ejector, drives a retriggerable eject pulse, counts good/bad items and batches.
// Exit events land DELAY cycles after the item strobe; items are never stalled (no backpressure).
module banda_sortare
    import banda_pkg::*;
#(
    parameter int DELAY     = DELAY_DEF,
    parameter int PULSE_LEN = PULSE_DEF,
    parameter int BATCH     = BATCH_DEF,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             item,
    input  logic             z,
    output logic             eject,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt,
    output logic             batch_done,
    output logic             busy
);

    localparam logic [3:0]       PCNT_LOAD  = 4'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] BATCH_LAST = CNT_W'(BATCH - 1);

    logic [2*DELAY-1:0] w_taps;
    logic [1:0]         w_exit;
    logic               w_good_exit;
    logic               w_bad_exit;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_pcnt;
    logic [3:0] w_pcnt_nxt;
    logic       r_eject;

    logic [CNT_W-1:0] r_good_cnt;
    logic [CNT_W-1:0] r_bad_cnt;
    logic [CNT_W-1:0] r_batch_cnt;
    logic             r_batch_done;

    banda_delay_line #(
        .DEPTH (DELAY),
        .W     (2)
    ) u_delay (
        .clk    (clk),
        .i_clr  (reset),
        .i_dat  ({item, item & z}),
        .o_taps (w_taps),
        .o_dat  (w_exit)
    );

    assign w_good_exit = w_exit[1] & ~w_exit[0];
    assign w_bad_exit  = w_exit[1] &  w_exit[0];

    always_comb begin
        w_state_nxt = r_state;
        w_pcnt_nxt  = r_pcnt;
        case (r_state)
            IDLE: begin
                if (w_bad_exit) begin
                    w_state_nxt = EJECT;
                    w_pcnt_nxt  = PCNT_LOAD;
                end
            end
            EJECT: begin
                // A reject arriving on the last pulse cycle still retriggers, so eject never dips.
                if (w_bad_exit) begin
                    w_pcnt_nxt = PCNT_LOAD;
                end else if (r_pcnt == 4'd0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_pcnt_nxt = r_pcnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_pcnt_nxt  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_pcnt  <= 4'd0;
            r_eject <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pcnt  <= w_pcnt_nxt;
            r_eject <= (w_state_nxt == EJECT);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_good_cnt   <= '0;
            r_bad_cnt    <= '0;
            r_batch_cnt  <= '0;
            r_batch_done <= 1'b0;
        end else begin
            r_batch_done <= 1'b0;
            if (w_good_exit) begin
                if (r_good_cnt != '1) r_good_cnt <= r_good_cnt + 1'b1;
                if (r_batch_cnt == BATCH_LAST) begin
                    r_batch_cnt  <= '0;
                    r_batch_done <= 1'b1;
                end else begin
                    r_batch_cnt <= r_batch_cnt + 1'b1;
                end
            end
            if (w_bad_exit && (r_bad_cnt != '1)) r_bad_cnt <= r_bad_cnt + 1'b1;
        end
    end

    // A stage's rej bit is only ever set alongside its valid bit, so OR-ing every tap equals OR-ing the valids.
    assign busy       = (|w_taps) | r_eject;
    assign eject      = r_eject;
    assign good_cnt   = r_good_cnt;
    assign bad_cnt    = r_bad_cnt;
    assign batch_done = r_batch_done;

endmodule

// File: tb/tb_banda_sortare.sv
// Table-driven bench for banda_sortare: per-edge vectors with expected outputs, plus a saturation run on a narrow build.
module tb_banda_sortare;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, item, z;
    logic       eject, batch_done, busy;
    logic [7:0] good_cnt, bad_cnt;

    logic       reset2, item2, z2;
    logic       eject2, bdone2, busy2;
    logic [1:0] good2, bad2;

    banda_sortare dut (
        .clk        (clk),
        .reset      (reset),
        .item       (item),
        .z          (z),
        .eject      (eject),
        .good_cnt   (good_cnt),
        .bad_cnt    (bad_cnt),
        .batch_done (batch_done),
        .busy       (busy)
    );

    banda_sortare #(.CNT_W(2), .BATCH(3)) dut_n (
        .clk        (clk),
        .reset      (reset2),
        .item       (item2),
        .z          (z2),
        .eject      (eject2),
        .good_cnt   (good2),
        .bad_cnt    (bad2),
        .batch_done (bdone2),
        .busy       (busy2)
    );

    typedef struct {
        logic rst;
        logic itm;
        logic zz;
        logic ej;
        int   g;
        int   b;
        logic bd;
        logic bs;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input logic r, input logic i, input logic zz, input logic ej,
                       input int g, input int b, input logic bd, input logic bs);
        vec_t v;
        v.rst = r; v.itm = i; v.zz = zz; v.ej = ej;
        v.g = g; v.b = b; v.bd = bd; v.bs = bs;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int ej_rises;
        int bd_pulses;
        logic prev_ej;

        reset = 1'b1; item = 1'b0; z = 1'b0;
        reset2 = 1'b1; item2 = 1'b0; z2 = 1'b0;

        // rows: reset, item, z -> eject, good_cnt, bad_cnt, batch_done, busy (after that edge)
        // single good item, z toggling while item=0 must be ignored
        add(1,0,0, 0,0,0,0,0);
        add(0,1,0, 0,0,0,0,1);
        add(0,0,1, 0,0,0,0,1);
        add(0,0,1, 0,0,0,0,1);
        add(0,0,0, 0,0,0,0,1);
        add(0,0,0, 0,1,0,0,0);
        add(0,0,1, 0,1,0,0,0);
        // isolated reject
        add(1,0,0, 0,0,0,0,0);
        add(0,1,1, 0,0,0,0,1);
        add(0,0,0, 0,0,0,0,1);
        add(0,0,0, 0,0,0,0,1);
        add(0,0,0, 0,0,0,0,1);
        add(0,0,0, 1,0,1,0,1);
        add(0,0,0, 1,0,1,0,1);
        add(0,0,0, 1,0,1,0,1);
        add(0,0,0, 0,0,1,0,0);
        add(0,0,0, 0,0,1,0,0);
        // rejects at edges 0 and 2: pulse merges over edges 4..8
        add(1,0,0, 0,0,0,0,0);
        add(0,1,1, 0,0,0,0,1);
        add(0,0,0, 0,0,0,0,1);
        add(0,1,1, 0,0,0,0,1);
        add(0,0,0, 0,0,0,0,1);
        add(0,0,0, 1,0,1,0,1);
        add(0,0,0, 1,0,1,0,1);
        add(0,0,0, 1,0,2,0,1);
        add(0,0,0, 1,0,2,0,1);
        add(0,0,0, 1,0,2,0,1);
        add(0,0,0, 0,0,2,0,0);
        // rejects at edges 0 and 3: retrigger on the final pulse cycle
        add(1,0,0, 0,0,0,0,0);
        add(0,1,1, 0,0,0,0,1);
        add(0,0,0, 0,0,0,0,1);
        add(0,0,0, 0,0,0,0,1);
        add(0,1,1, 0,0,0,0,1);
        add(0,0,0, 1,0,1,0,1);
        add(0,0,0, 1,0,1,0,1);
        add(0,0,0, 1,0,1,0,1);
        add(0,0,0, 1,0,2,0,1);
        add(0,0,0, 1,0,2,0,1);
        add(0,0,0, 1,0,2,0,1);
        add(0,0,0, 0,0,2,0,0);
        // twenty back-to-back good items: batch_done after edges 13 and 23
        add(1,0,0, 0,0,0,0,0);
        for (int k = 0; k < 25; k++)
            add(0, (k < 20), 0, 0, (k < 4) ? 0 : ((k - 3 > 20) ? 20 : k - 3), 0,
                (k == 13 || k == 23), (k < 23));
        // reset in the middle of an eject pulse
        add(1,0,0, 0,0,0,0,0);
        add(0,1,1, 0,0,0,0,1);
        add(0,0,0, 0,0,0,0,1);
        add(0,0,0, 0,0,0,0,1);
        add(0,0,0, 0,0,0,0,1);
        add(0,0,0, 1,0,1,0,1);
        add(1,0,0, 0,0,0,0,0);
        for (int k = 0; k < 4; k++) add(0,0,0, 0,0,0,0,0);

        foreach (tbl[k]) begin
            reset = tbl[k].rst; item = tbl[k].itm; z = tbl[k].zz;
            @(posedge clk); #1;
            chk($sformatf("row%0d eject", k),      eject,      tbl[k].ej);
            chk($sformatf("row%0d good_cnt", k),   good_cnt,   tbl[k].g);
            chk($sformatf("row%0d bad_cnt", k),    bad_cnt,    tbl[k].b);
            chk($sformatf("row%0d batch_done", k), batch_done, tbl[k].bd);
            chk($sformatf("row%0d busy", k),       busy,       tbl[k].bs);
        end

        // narrow build: five spaced rejects, then six good items
        reset2 = 1'b1;
        @(posedge clk); #1;
        chk("narrow reset bad_cnt", bad2, 0);
        chk("narrow reset eject", eject2, 0);
        reset2 = 1'b0;
        ej_rises = 0; bd_pulses = 0; prev_ej = 1'b0;
        for (int k = 0; k < 41; k++) begin
            item2 = ((k % 4 == 0) && k <= 16) || (k >= 24 && k <= 29);
            z2    = (k <= 16);
            @(posedge clk); #1;
            if (eject2 && !prev_ej) ej_rises++;
            prev_ej = eject2;
            if (bdone2) bd_pulses++;
            if (k == 12) chk("narrow bad_cnt at 3rd reject", bad2, 3);
            if (k == 20) chk("narrow bad_cnt saturated", bad2, 3);
        end
        chk("narrow eject pulses", ej_rises, 5);
        chk("narrow good_cnt saturated", good2, 3);
        chk("narrow batch pulses", bd_pulses, 2);
        chk("narrow busy idle", busy2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/banda_sortare.md
Name: banda_sortare

Overview:
Downstream sorting stage of the assembly line. It consumes the per-item reject decision `z` produced by the inspection stage `final`. It delays that decision by the conveyor travel time to the ejector, then drives a timed ejector pulse for rejected items. It also keeps good/bad item counts and signals completion of each batch of good items.

Parameters:
- DELAY, 4: clock cycles of travel from the inspection point to the ejector; legal range 1..15.
- PULSE_LEN, 3: ejector pulse length in cycles; legal range 1..15.
- BATCH, 10: good items per batch; legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the item counters.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- item  in  1  one-cycle strobe; an item is at the inspection point in this cycle.
- z  in  1  reject decision from `final` (1 = reject); sampled only when item=1.
- eject  out  1  ejector actuator drive, registered.
- good_cnt  out  CNT_W  total good items passed; saturating.
- bad_cnt  out  CNT_W  total items ejected; saturating.
- batch_done  out  1  one-cycle pulse when the BATCH-th good item of the current batch passes.
- busy  out  1  high while any item is in the delay line or eject=1.

Behaviour:
- Reset:
  - On the edge where reset=1: eject=0, good_cnt=0, bad_cnt=0, batch_done=0, busy=0.
  - Delay line, batch counter and FSM are cleared.
  - Items in flight are discarded, not counted.
  - Reset has priority over every other event.
  - Reset mid-pulse: eject is 0 after that edge.
- Delay line:
  - DELAY-deep shift register of {valid, rej}, advancing every cycle.
  - Stage 0 loads {item, item & z}.
  - Item strobes may occur on consecutive cycles; every item is tracked independently.
- Exit event: the item sampled at edge N reaches the exit at edge N+DELAY.
  - Good exit (rej=0): good_cnt increments at that edge, saturating at 2^CNT_W-1. The batch counter increments.
  - Good exit that brings the batch counter to BATCH: batch_done=1 for exactly one cycle after that edge. The batch counter returns to 0 at the same edge and keeps wrapping even when good_cnt is saturated.
  - Bad exit (rej=1): bad_cnt increments at that edge, saturating. The ejector FSM is triggered.
- Ejector FSM:
  - States: IDLE, EJECT, plus a pulse counter pcnt.
  - IDLE → EJECT on a bad exit; eject=1 after that edge; pcnt is loaded with PULSE_LEN-1.
  - In EJECT, pcnt decrements each cycle. At pcnt=0 with no new bad exit, the FSM returns to IDLE and eject=0 after that edge.
  - A bad exit while in EJECT, including on the final cycle, reloads pcnt to PULSE_LEN-1 (retrigger). The pulse extends; eject never glitches low between back-to-back rejects.
  - For an isolated reject sampled at edge N, eject=1 in the PULSE_LEN cycles following edges N+DELAY .. N+DELAY+PULSE_LEN-1.
- busy is the OR of all delay-line valid bits and eject (combinational from registers).
- z is ignored when item=0.

Decomposition:
- Package banda_pkg holds:
  - enum state_t {IDLE, EJECT};
  - default constants DELAY_DEF=4, PULSE_DEF=3, BATCH_DEF=10.
- Sub-module banda_delay_line (parameters DEPTH, W): a plain shift register with synchronous clear. It is instantiated with W=2 for {valid, rej}.
- FSM, counters and batch logic stay in banda_sortare.

Test Plan:
1. Reset, then item=1,z=0 at edge 0 → good_cnt=1 after edge 4, eject stays 0, busy high for cycles 1..4 and 0 after edge 4.
2. Item=1,z=1 at edge 0 → eject=1 after edges 4..6 and 0 after edge 7; bad_cnt=1 after edge 4.
3. Rejects at edges 0 and 2 → eject continuously 1 after edges 4..8, 0 after edge 9; bad_cnt=2.
4. Ten good items on consecutive edges 0..9 → batch_done is a single pulse after edge 13; good_cnt=10. Ten more good items → a second pulse; good_cnt=20.
5. Reject at edge 0, reset=1 at edge 5 → eject=0 and bad_cnt=0 after edge 5; busy=0; no further activity.
6. CNT_W=2 build, five rejects spaced 4 cycles apart → bad_cnt saturates at 3; eject still pulses five times.
